// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache to physical-memory arbiter.
// LINE_W is the cache line width used by both caches and the memory port.
package cache_arb_pkg;

   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

endpackage : cache_arb_pkg

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// The winner's command is registered onto pmem and held until pmem_resp; the response is routed back to the winner only.
import cache_arb_pkg::*;

module cache_arbiter #(
   parameter int WIDTH  = LINE_W,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [WIDTH-1:0]  i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [WIDTH-1:0]  d_wdata,
   output logic [WIDTH-1:0]  d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [WIDTH-1:0]  pmem_wdata,
   input  logic [WIDTH-1:0]  pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state, state_nxt;
   logic       last_grant, last_grant_nxt;   // 0 = I served last, 1 = D served last
   logic       i_req, d_req;
   logic       grant_i, grant_d;
   logic       ld_i, ld_d, clr_cmd;

   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   // On contention the requester that did not win last time is chosen.
   assign grant_d = d_req & (~i_req | ~last_grant);
   assign grant_i = i_req & ~grant_d;

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      ld_i           = 1'b0;
      ld_d           = 1'b0;
      clr_cmd        = 1'b0;
      i_resp         = 1'b0;
      d_resp         = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d) begin
               ld_d           = 1'b1;
               last_grant_nxt = 1'b1;
               state_nxt      = BUSY_D;
            end else if (grant_i) begin
               ld_i           = 1'b1;
               last_grant_nxt = 1'b0;
               state_nxt      = BUSY_I;
            end
         end
         BUSY_I: begin
            if (pmem_resp) begin
               i_resp    = 1'b1;
               clr_cmd   = 1'b1;
               state_nxt = DONE;
            end
         end
         BUSY_D: begin
            if (pmem_resp) begin
               d_resp    = 1'b1;
               clr_cmd   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Command registers load only on a grant, so requester inputs never reach pmem combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
      end else if (ld_i) begin
         pmem_read  <= 1'b1;
         pmem_write <= 1'b0;
         pmem_addr  <= i_addr;
      end else if (ld_d) begin
         pmem_read  <= d_read & ~d_write;
         pmem_write <= d_write;
         pmem_addr  <= d_addr;
         pmem_wdata <= d_wdata;
      end else if (clr_cmd) begin
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end
   end

   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule : cache_arbiter

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache (read-only, line fills) and the data cache (line fills and write-backs). It sits between the two caches' requestor sides and main memory. It grants one cache at a time, registers the winner's command onto the memory port, and holds it there until memory responds. It then routes the response back to the winner only.

## Interface
Parameters:
- WIDTH, 256, cache line width in bits (pmem data width)
- ADDR_W, 32, address width

Ports:
- clk  in  1  sole clock; every register updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_read  in  1  I-cache line-fill request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  WIDTH  fill data to I-cache, valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line-fill request, held until d_resp
- d_write  in  1  D-cache write-back request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  WIDTH  write-back data
- d_rdata  out  WIDTH  fill data to D-cache, valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read command, registered
- pmem_write  out  1  memory write command, registered
- pmem_addr  out  ADDR_W  registered command address
- pmem_wdata  out  WIDTH  registered write data
- pmem_rdata  in  WIDTH  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE with no request: stay. With one requester active: grant it. With both active: grant the requester not in last_grant. last_grant is a 1-bit register; 0 = I, 1 = D.
- On grant in IDLE:
  - Register pmem_addr from the winner.
  - For D: pmem_read = d_read & ~d_write, pmem_write = d_write, pmem_wdata = d_wdata.
  - For I: pmem_read = 1, pmem_write = 0.
  - Update last_grant. Go to BUSY_I or BUSY_D.
- BUSY_x: pmem command stays constant until pmem_resp. Requester inputs are not re-sampled.
- Cycle in which pmem_resp=1 while BUSY_x:
  - x_resp = 1 combinationally. x_rdata = pmem_rdata.
  - On the edge, clear pmem_read and pmem_write, then go to DONE.
- DONE: one bubble cycle so the served cache can drop its request. Ignore all requests; go to IDLE.
- i_rdata and d_rdata are wired to pmem_rdata at all times. Only resp is gated.
- Not-granted requester: resp held 0, and its request stays pending.
- pmem_resp outside BUSY_x: ignored, no resp forwarded.
- d_read and d_write both high: treated as a write. This is a protocol violation; the bench flags it with an assertion.
- Reset (rst_n low, any state, including mid-transaction):
  - State goes to IDLE immediately and last_grant to 1 (I wins the first contention).
  - pmem_read, pmem_write, i_resp, d_resp = 0. pmem_addr and pmem_wdata = 0.
  - An in-flight memory transaction is abandoned.

## Timing
- Request first sampled high in IDLE at cycle N: pmem command is visible at N+1.
- pmem_resp at cycle M (≥ N+1): client resp at M, same cycle, zero added latency. pmem command low at M+1, DONE at M+1, IDLE at M+2.
- Earliest next grant is at M+2, with its command at M+3. Minimum overhead per transaction is 2 cycles plus memory latency.
- Back-to-back contention alternates strictly I, D, I, D. Neither requester waits more than one other transaction.
- No combinational path from any requester input to any pmem output.

## Structure
- Package cache_arb_pkg: enum arb_state_t {IDLE, BUSY_I, BUSY_D, DONE}, and constant LINE_W = 256. The caches share LINE_W.
- Single module. There is no natural sub-module; the round-robin choice is one line of logic.

## Test plan
- I only: i_read=1, i_addr=0x0000_1000, memory responds 4 cycles after the command. Expect pmem_read high from N+1 with pmem_addr=0x1000, pmem_write=0. i_resp=1 in the same cycle as pmem_resp, i_rdata equal to the memory pattern, d_resp=0 throughout.
- D write-back: d_write=1, d_addr=0x0000_2040, d_wdata=all-0xA5. Expect pmem_write=1 and pmem_wdata=all-0xA5 held until pmem_resp, d_resp pulse, pmem_read=0 throughout.
- Contention after reset: i_read and d_read rise together, with requests held continuously. Expect I served first, then D. Grants continue I, D, I across 4 transactions, with ≥2 cycles between resp and the next command.
- Hold stability: change d_addr and d_wdata while I is BUSY. Expect pmem_addr unchanged until i_resp, and the D command to use the values present at its grant.
- Reset mid-BUSY_D: assert rst_n=0 with pmem_write high. Expect all outputs 0 asynchronously. After release with i_read and d_read both high, I is granted first.
- Stray pmem_resp in IDLE or DONE: expect no i_resp or d_resp and no state change.
